eth_fcs_arbiter: RTL and testbench

Frame-granular round-robin arbiter that shares one Ethernet FCS generator between S_COUNT AXI-stream sources. It grants one source per frame and muxes that source onto a single stream, which drives both the shared FCS engine and the downstream path. It tags each frame with its source index and re-associates the engine's FCS result with that index. It sits between the per-port MAC TX/RX frame sources and the shared FCS generator instance.

---
 rtl/eth_fcs_arbiter.sv | 135 +++++++++++++
 tb/tb_eth_fcs_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_fcs_arbiter.sv
// Frame-granular round-robin arbiter sharing one FCS engine between S_COUNT AXI-stream sources.
// Each frame is tagged with its source index so the engine's FCS result can be routed back to its owner.
module eth_fcs_arbiter #(
  parameter int S_COUNT    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int ID_WIDTH   = $clog2(S_COUNT)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [S_COUNT*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [S_COUNT*KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic [S_COUNT-1:0]            s_axis_tvalid,
  output logic [S_COUNT-1:0]            s_axis_tready,
  input  logic [S_COUNT-1:0]            s_axis_tlast,
  input  logic [S_COUNT-1:0]            s_axis_tuser,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]         m_axis_tkeep,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic                          m_axis_tuser,
  output logic [ID_WIDTH-1:0]           m_axis_tid,
  output logic                          crc_tvalid,
  input  logic [31:0]                   fcs_in,
  input  logic                          fcs_in_valid,
  output logic [31:0]                   fcs_out,
  output logic                          fcs_out_valid,
  output logic [ID_WIDTH-1:0]           fcs_out_id,
  output logic                          fcs_out_error
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t              state, state_next;
  logic [ID_WIDTH-1:0] grant, last_grant, tag_id;
  logic                tag_err, tag_pending;
  logic                last_hs;

  logic [DATA_WIDTH-1:0] src_data [S_COUNT];
  logic [KEEP_WIDTH-1:0] src_keep [S_COUNT];

  for (genvar k = 0; k < S_COUNT; k++) begin : g_src
    assign src_data[k] = s_axis_tdata[k*DATA_WIDTH +: DATA_WIDTH];
    assign src_keep[k] = s_axis_tkeep[k*KEEP_WIDTH +: KEEP_WIDTH];
  end

  // First requester after the previous owner, wrapping modulo S_COUNT.
  function automatic logic [ID_WIDTH-1:0] rr_pick(input logic [S_COUNT-1:0] req,
                                                  input logic [ID_WIDTH-1:0] last);
    logic [ID_WIDTH-1:0] pick;
    logic [ID_WIDTH-1:0] cand;
    logic                found;
    pick  = '0;
    found = 1'b0;
    for (int i = 1; i <= S_COUNT; i++) begin
      cand = ID_WIDTH'((int'(last) + i) % S_COUNT);
      if (!found && req[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  always_comb begin
    s_axis_tready = '0;
    m_axis_tvalid = 1'b0;
    if (state == ACTIVE) begin
      s_axis_tready[grant] = m_axis_tready;
      m_axis_tvalid        = s_axis_tvalid[grant];
    end
  end

  assign m_axis_tdata = src_data[grant];
  assign m_axis_tkeep = src_keep[grant];
  assign m_axis_tlast = s_axis_tlast[grant];
  assign m_axis_tuser = s_axis_tuser[grant];
  assign m_axis_tid   = grant;
  assign crc_tvalid   = m_axis_tvalid & m_axis_tready;
  assign last_hs      = crc_tvalid & m_axis_tlast;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (|s_axis_tvalid) state_next = ACTIVE;
      ACTIVE:  if (last_hs) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant      <= '0;
      last_grant <= ID_WIDTH'(S_COUNT - 1);
    end else begin
      if (state == IDLE && |s_axis_tvalid) grant <= rr_pick(s_axis_tvalid, last_grant);
      if (last_hs) last_grant <= grant;
    end
  end

  // Tag captured at the closing beat; the engine answers one cycle later.
  always_ff @(posedge clk) begin
    if (last_hs) begin
      tag_id  <= grant;
      tag_err <= m_axis_tuser;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_pending   <= 1'b0;
      fcs_out       <= '0;
      fcs_out_id    <= '0;
      fcs_out_error <= 1'b0;
      fcs_out_valid <= 1'b0;
    end else begin
      fcs_out_valid <= 1'b0;
      if (fcs_in_valid && tag_pending) begin
        fcs_out       <= fcs_in;
        fcs_out_id    <= tag_id;
        fcs_out_error <= tag_err;
        fcs_out_valid <= 1'b1;
        tag_pending   <= 1'b0;
      end
      if (last_hs) tag_pending <= 1'b1;
    end
  end

endmodule

// File: tb/tb_eth_fcs_arbiter.sv
// Directed bench for eth_fcs_arbiter with a behavioural CRC-32 engine attached to the muxed stream.
// Sources are modelled as beat tables; downstream beats and fcs_out pulses are logged per cycle.
module tb_eth_fcs_arbiter;
  localparam int S  = 4;
  localparam int DW = 8;
  localparam int KW = 1;
  localparam int IW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [S*DW-1:0] s_axis_tdata;
  logic [S*KW-1:0] s_axis_tkeep;
  logic [S-1:0]    s_axis_tvalid, s_axis_tready, s_axis_tlast, s_axis_tuser;
  logic [DW-1:0]   m_axis_tdata;
  logic [KW-1:0]   m_axis_tkeep;
  logic            m_axis_tvalid, m_axis_tready, m_axis_tlast, m_axis_tuser;
  logic [IW-1:0]   m_axis_tid;
  logic            crc_tvalid;
  logic [31:0]     fcs_in;
  logic            fcs_in_valid;
  logic [31:0]     fcs_out;
  logic            fcs_out_valid;
  logic [IW-1:0]   fcs_out_id;
  logic            fcs_out_error;

  eth_fcs_arbiter #(.S_COUNT(S), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .m_axis_tid(m_axis_tid), .crc_tvalid(crc_tvalid),
    .fcs_in(fcs_in), .fcs_in_valid(fcs_in_valid),
    .fcs_out(fcs_out), .fcs_out_valid(fcs_out_valid), .fcs_out_id(fcs_out_id),
    .fcs_out_error(fcs_out_error)
  );

  function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] d);
    logic [31:0] c;
    c = c_in ^ {24'h0, d};
    for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    return c;
  endfunction

  // Behavioural FCS engine: fed by crc_tvalid, answers one cycle after the last beat.
  logic [31:0] eng_acc, eng_fcs;
  logic        eng_valid, inj_valid;
  logic [31:0] inj_fcs;
  always @(posedge clk) begin
    if (rst) begin
      eng_acc   <= 32'hFFFFFFFF;
      eng_fcs   <= 32'h0;
      eng_valid <= 1'b0;
    end else begin
      eng_valid <= 1'b0;
      if (crc_tvalid) begin
        if (m_axis_tlast) begin
          eng_fcs   <= ~crc_byte(eng_acc, m_axis_tdata);
          eng_valid <= 1'b1;
          eng_acc   <= 32'hFFFFFFFF;
        end else begin
          eng_acc <= crc_byte(eng_acc, m_axis_tdata);
        end
      end
    end
  end
  assign fcs_in_valid = eng_valid | inj_valid;
  assign fcs_in       = inj_valid ? inj_fcs : eng_fcs;

  logic [7:0]  src_d [S][64];
  logic        src_l [S][64];
  logic        src_u [S][64];
  int          wr_ptr [S];
  int          rd_ptr [S];
  logic [31:0] acc [S];
  logic [31:0] exp_fcs [S][8];
  int          exp_nf [S];
  logic [S-1:0] hs;

  logic [IW-1:0] rx_tid [256];
  logic [7:0]    rx_data [256];
  int            rx_cyc [256];
  int            rx_n;
  logic [31:0]   fo_val [16];
  logic [IW-1:0] fo_id [16];
  logic          fo_err [16];
  int            fo_cyc [16];
  int            fo_n;

  int   cyc, checks, errors;
  logic ds_ready, bp_mode;
  assign m_axis_tready = ds_ready;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_src();
    for (int k = 0; k < S; k++) begin
      logic v;
      v = rd_ptr[k] < wr_ptr[k];
      s_axis_tvalid[k]      = v;
      s_axis_tdata[k*DW +: DW] = v ? src_d[k][rd_ptr[k]] : 8'h00;
      s_axis_tkeep[k]       = 1'b1;
      s_axis_tlast[k]       = v ? src_l[k][rd_ptr[k]] : 1'b0;
      s_axis_tuser[k]       = v ? src_u[k][rd_ptr[k]] : 1'b0;
    end
  endtask

  task automatic push_beat(input int k, input logic [7:0] d, input logic l, input logic u);
    src_d[k][wr_ptr[k]] = d;
    src_l[k][wr_ptr[k]] = l;
    src_u[k][wr_ptr[k]] = u;
    wr_ptr[k]++;
    acc[k] = crc_byte(acc[k], d);
    if (l) begin
      exp_fcs[k][exp_nf[k]] = ~acc[k];
      exp_nf[k]++;
      acc[k] = 32'hFFFFFFFF;
    end
  endtask

  task automatic clear_logs();
    rx_n = 0;
    fo_n = 0;
    for (int k = 0; k < S; k++) begin
      exp_nf[k] = 0;
      if (rd_ptr[k] == wr_ptr[k]) begin
        rd_ptr[k] = 0;
        wr_ptr[k] = 0;
      end
    end
  endtask

  task automatic cycle();
    #1;
    if (m_axis_tvalid && m_axis_tready && rx_n < 256) begin
      rx_tid[rx_n]  = m_axis_tid;
      rx_data[rx_n] = m_axis_tdata;
      rx_cyc[rx_n]  = cyc;
      rx_n++;
    end
    if (fcs_out_valid && fo_n < 16) begin
      fo_val[fo_n] = fcs_out;
      fo_id[fo_n]  = fcs_out_id;
      fo_err[fo_n] = fcs_out_error;
      fo_cyc[fo_n] = cyc;
      fo_n++;
    end
    if (bp_mode) check("bp_crc_tvalid", 32'(crc_tvalid), 32'(m_axis_tvalid & m_axis_tready));
    hs = s_axis_tvalid & s_axis_tready;
    @(posedge clk);
    #1;
    for (int k = 0; k < S; k++) if (hs[k]) rd_ptr[k]++;
    drive_src();
    @(negedge clk);
    cyc++;
  endtask

  task automatic run_until_fo(input int n, input int budget);
    int b;
    b = 0;
    while (fo_n < n && b < budget) begin
      cycle();
      b++;
    end
    if (fo_n < n) check("timeout_fcs_pulse", 32'(fo_n), 32'(n));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_s_tready"}, 32'(s_axis_tready), 32'h0);
    check({tag, "_m_tvalid"}, 32'(m_axis_tvalid), 32'h0);
    check({tag, "_m_tid"}, 32'(m_axis_tid), 32'h0);
    check({tag, "_fcs_valid"}, 32'(fcs_out_valid), 32'h0);
    check({tag, "_fcs"}, fcs_out, 32'h0);
    check({tag, "_fcs_id"}, 32'(fcs_out_id), 32'h0);
    check({tag, "_fcs_err"}, 32'(fcs_out_error), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    string       s;
    int          bad, rel_cyc, b;
    int          order [5];
    logic [31:0] e0, e1;

    rst = 1'b1; ds_ready = 1'b1; bp_mode = 1'b0; inj_valid = 1'b0; inj_fcs = 32'h0;
    cyc = 0; checks = 0; errors = 0; rx_n = 0; fo_n = 0;
    for (int k = 0; k < S; k++) begin
      wr_ptr[k] = 0; rd_ptr[k] = 0; acc[k] = 32'hFFFFFFFF; exp_nf[k] = 0;
    end

    // Single frame "123456789" from source 1; requests are held during reset
    s = "123456789";
    for (int i = 0; i < 9; i++) push_beat(1, s[i], i == 8, 1'b0);
    drive_src();
    @(negedge clk);
    cycle(); cycle();
    check_reset_outputs("reset");
    rst = 1'b0;
    rel_cyc = cyc;
    rx_n = 0; fo_n = 0;
    run_until_fo(1, 40);
    check("s1_beats", 32'(rx_n), 32'd9);
    bad = 0;
    for (int i = 0; i < 9; i++) if (rx_data[i] !== s[i] || rx_tid[i] !== 2'd1) bad++;
    check("s1_data_tid", 32'(bad), 32'd0);
    check("s1_latency", 32'(rx_cyc[0] - rel_cyc), 32'd1);
    check("s1_fcs", fo_val[0], 32'hCBF43926);
    check("s1_fcs_id", 32'(fo_id[0]), 32'd1);
    check("s1_fcs_err", 32'(fo_err[0]), 32'd0);
    check("s1_pulse_delay", 32'(fo_cyc[0] - rx_cyc[8]), 32'd2);
    cycle(); cycle(); cycle();
    check("s1_single_pulse", 32'(fo_n), 32'd1);
    check("s1_hold_fcs", fcs_out, 32'hCBF43926);
    check("s1_hold_valid", 32'(fcs_out_valid), 32'd0);

    // Round-robin: all four sources request from reset, source 0 has two frames
    rst = 1'b1;
    cycle();
    clear_logs();
    for (int k = 0; k < S; k++)
      for (int j = 0; j < 3; j++) push_beat(k, 8'((k + 1) * 16 + j), j == 2, 1'b0);
    for (int j = 0; j < 3; j++) push_beat(0, 8'(8'hA0 + j), j == 2, 1'b0);
    drive_src();
    cycle();
    rst = 1'b0;
    run_until_fo(5, 80);
    order = '{0, 1, 2, 3, 0};
    bad = 0;
    for (int f = 0; f < 5; f++)
      for (int j = 0; j < 3; j++)
        if (rx_data[3*f+j] !== ((f == 4) ? 8'(8'hA0 + j) : 8'((order[f] + 1) * 16 + j))) bad++;
    check("rr_data", 32'(bad), 32'd0);
    for (int f = 0; f < 5; f++) begin
      check($sformatf("rr_tid_f%0d", f), 32'(rx_tid[3*f]), 32'(order[f]));
      check($sformatf("rr_fcs_id_f%0d", f), 32'(fo_id[f]), 32'(order[f]));
      check($sformatf("rr_fcs_f%0d", f), fo_val[f],
            (f == 4) ? exp_fcs[0][1] : exp_fcs[order[f]][0]);
      if (f > 0) check($sformatf("rr_gap_f%0d", f), 32'(rx_cyc[3*f] - rx_cyc[3*f-1]), 32'd2);
    end

    // Fairness: sources 0, 2 and 3 request after source 0 was served last
    clear_logs();
    push_beat(2, 8'h21, 1'b1, 1'b0);
    push_beat(0, 8'h01, 1'b1, 1'b0);
    push_beat(3, 8'h31, 1'b1, 1'b0);
    drive_src();
    run_until_fo(3, 40);
    check("fair_tid0", 32'(rx_tid[0]), 32'd2);
    check("fair_tid1", 32'(rx_tid[1]), 32'd3);
    check("fair_tid2", 32'(rx_tid[2]), 32'd0);
    check("fair_fcs_id1", 32'(fo_id[1]), 32'd3);
    check("fair_fcs_3", fo_val[1], exp_fcs[3][0]);

    // Backpressure: downstream ready alternates during a 6-beat frame from source 0
    clear_logs();
    for (int j = 0; j < 6; j++) push_beat(0, 8'(8'hC0 + j * 7), j == 5, 1'b0);
    drive_src();
    bp_mode = 1'b1;
    b = 0;
    while (fo_n < 1 && b < 60) begin
      ds_ready = (b % 2 == 0);
      cycle();
      b++;
    end
    bp_mode = 1'b0;
    ds_ready = 1'b1;
    if (fo_n < 1) check("timeout_bp_pulse", 32'(fo_n), 32'd1);
    check("bp_beats", 32'(rx_n), 32'd6);
    bad = 0;
    for (int j = 0; j < 6; j++) if (rx_data[j] !== 8'(8'hC0 + j * 7)) bad++;
    check("bp_data", 32'(bad), 32'd0);
    check("bp_fcs", fo_val[0], exp_fcs[0][0]);

    // Back-to-back one-beat frames, the second flagged bad
    rst = 1'b1;
    clear_logs();
    push_beat(0, 8'h77, 1'b1, 1'b0);
    push_beat(1, 8'h88, 1'b1, 1'b1);
    e0 = exp_fcs[0][0];
    e1 = exp_fcs[1][0];
    drive_src();
    cycle(); cycle();
    rst = 1'b0;
    run_until_fo(2, 40);
    check("b2b_id0", 32'(fo_id[0]), 32'd0);
    check("b2b_id1", 32'(fo_id[1]), 32'd1);
    check("b2b_err0", 32'(fo_err[0]), 32'd0);
    check("b2b_err1", 32'(fo_err[1]), 32'd1);
    check("b2b_spacing", 32'(fo_cyc[1] - fo_cyc[0]), 32'd2);
    check("b2b_fcs0", fo_val[0], e0);
    check("b2b_fcs1", fo_val[1], e1);

    // A stray engine valid with no frame outstanding is ignored
    inj_fcs = 32'hDEADBEEF;
    inj_valid = 1'b1;
    cycle();
    inj_valid = 1'b0;
    cycle(); cycle();
    check("stray_no_pulse", 32'(fo_n), 32'd2);
    check("stray_hold", fcs_out, e1);

    // Reset on beat 3 of a 5-beat frame from source 2, then a clean frame
    clear_logs();
    for (int j = 0; j < 5; j++) push_beat(2, 8'(8'hE0 + j), j == 4, 1'b0);
    drive_src();
    b = 0;
    while (rd_ptr[2] < 2 && b < 20) begin
      cycle();
      b++;
    end
    check("mid_reach_beat3", 32'(rd_ptr[2]), 32'd2);
    rst = 1'b1;
    cycle();
    check_reset_outputs("midrst");
    rd_ptr[2] = wr_ptr[2];
    drive_src();
    rst = 1'b0;
    cycle(); cycle(); cycle();
    check("midrst_no_pulse", 32'(fo_n), 32'd0);
    for (int j = 0; j < 4; j++) push_beat(2, 8'(8'h40 + j), j == 3, 1'b0);
    drive_src();
    run_until_fo(1, 40);
    check("midrst_fcs", fo_val[0], exp_fcs[2][1]);
    check("midrst_fcs_id", 32'(fo_id[0]), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
